// File: rtl/result_display_driver.sv
// ALU result display: samples result/flag, converts the result to BCD with a sequential
// double-dabble FSM and scans a multiplexed common-anode 7-segment display.
module result_display_driver #(
    parameter int DATA_W      = 4,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] result,
    input  logic              flag,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an,
    output logic              busy
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + DATA_W;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_e;

    // Input stage
    logic [DATA_W-1:0] result_q;
    logic              flag_q;

    // Conversion FSM
    state_e            state_q, state_d;
    logic [DATA_W:0]   src_q, src_d;
    logic [SH_W-1:0]   sh_q, sh_d, sh_adj;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [BCD_W-1:0]  disp_bcd_q, disp_bcd_d;
    logic              disp_flag_q, disp_flag_d;

    // Scan
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              dp_q, dp_d;
    logic [3:0]        digit_a [DIGITS];
    logic [3:0]        digit_val;
    logic              upper_nz;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h7F;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            result_q <= result;
            flag_q   <= flag;
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d     = state_q;
        src_d       = src_q;
        sh_d        = sh_q;
        sh_adj      = sh_q;
        bit_d       = bit_q;
        disp_bcd_d  = disp_bcd_q;
        disp_flag_d = disp_flag_q;
        case (state_q)
            IDLE: begin
                if ({flag_q, result_q} != src_q) begin
                    src_d   = {flag_q, result_q};
                    sh_d    = {{BCD_W{1'b0}}, result_q};
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (sh_q[DATA_W+4*i +: 4] >= 4'd5)
                        sh_adj[DATA_W+4*i +: 4] = sh_q[DATA_W+4*i +: 4] + 4'd3;
                end
                sh_d  = {sh_adj[SH_W-2:0], 1'b0};
                bit_d = bit_q + BIT_W'(1);
                if (bit_q == BIT_LAST) state_d = LOAD;
            end
            LOAD: begin
                disp_bcd_d  = sh_q[SH_W-1 -: BCD_W];
                disp_flag_d = src_q[DATA_W];
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            src_q       <= '0;
            sh_q        <= '0;
            bit_q       <= '0;
            disp_bcd_q  <= '0;
            disp_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            sh_q        <= sh_d;
            bit_q       <= bit_d;
            disp_bcd_q  <= disp_bcd_d;
            disp_flag_q <= disp_flag_d;
        end
    end

    assign busy = (state_q != IDLE);

    // Scan slot: outputs are only re-registered on the counter wrap, so a new display
    // value never appears in the middle of a slot.
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        seg_d     = seg_q;
        an_d      = an_q;
        dp_d      = dp_q;
        upper_nz  = 1'b0;
        for (int j = 0; j < DIGITS; j++) digit_a[j] = disp_bcd_q[4*j +: 4];
        digit_val = '0;
        if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            digit_val = digit_a[idx_d];
            for (int j = 0; j < DIGITS; j++) begin
                if (IDX_W'(j) >= idx_d && digit_a[j] != 4'd0) upper_nz = 1'b1;
            end
            if (idx_d != '0 && !upper_nz) begin
                seg_d = 7'h7F;
                an_d  = '1;
            end else begin
                seg_d = decode(digit_val);
                an_d  = ~(DIGITS'(1) << idx_d);
            end
            dp_d = !((idx_d == '0) && disp_flag_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            idx_q <= IDX_LAST;
            seg_q <= 7'h7F;
            an_q  <= '1;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_result_display_driver.sv
// Scoreboard bench for result_display_driver: stimulus queues expected scan slots,
// a monitor pops and compares them whenever the display outputs change.
module tb_result_display_driver;
    localparam int DATA_W = 4;
    localparam int DIGITS = 2;
    localparam int RDIV   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] result = '0;
    logic              flag = 1'b0;
    logic [6:0]        seg;
    logic              dp;
    logic [DIGITS-1:0] an;
    logic              busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          digit;
        logic [1:0]  an;
        logic [6:0]  seg;
        logic        dp;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    result_display_driver #(
        .DATA_W     (DATA_W),
        .DIGITS     (DIGITS),
        .REFRESH_DIV(RDIV)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .result(result),
        .flag  (flag),
        .seg   (seg),
        .dp    (dp),
        .an    (an),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [1:0] a, input logic [6:0] s, input logic p,
                        input string name);
        exp_t e;
        e.digit = d;
        e.an    = a;
        e.seg   = s;
        e.dp    = p;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic [DATA_W-1:0] r, input logic f);
        @(negedge clk);
        result = r;
        flag   = f;
    endtask

    task automatic count_busy(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (busy) n++;
        end
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            check({name, "_drain"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Monitor: a change of {an,seg,dp} marks a new scan slot; slots alternate 0,1,0,...
    initial begin
        logic [9:0] prev;
        int         dig;
        int         gap;
        exp_t       e;
        prev = {2'b11, 7'h7F, 1'b1};
        dig  = 0;
        gap  = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                prev = {2'b11, 7'h7F, 1'b1};
                dig  = 0;
                gap  = 0;
            end else begin
                gap++;
                if ({an, seg, dp} != prev) begin
                    check("scan_gap", gap, RDIV);
                    prev = {an, seg, dp};
                    gap  = 0;
                    if (exp_q.size() > 0 && exp_q[0].digit == dig) begin
                        e = exp_q.pop_front();
                        check({e.name, "_an"}, an, e.an);
                        check({e.name, "_seg"}, seg, e.seg);
                        check({e.name, "_dp"}, dp, e.dp);
                    end
                    dig = (dig == DIGITS - 1) ? 0 : dig + 1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;

        // 1: reset mid-conversion, then first slot shows digit 0 = "0"
        repeat (2) @(negedge clk);
        rst = 1'b1;
        apply(4'd7, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t1_rst_seg", seg, 7'h7F);
        check("t1_rst_an", an, 2'b11);
        check("t1_rst_dp", dp, 1'b1);
        check("t1_rst_busy", busy, 1'b0);
        result = '0;
        flag   = 1'b0;
        push(0, 2'b10, 7'h40, 1'b1, "t1_d0");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drain("t1");

        // 2: value 9, tens blanked
        apply(4'd9, 1'b0);
        count_busy(12, n);
        check("t2_busy", n, 5);
        push(0, 2'b10, 7'h10, 1'b1, "t2_d0");
        push(1, 2'b11, 7'h7F, 1'b1, "t2_d1");
        drain("t2");

        // 3: value 12
        apply(4'd12, 1'b0);
        count_busy(12, n);
        check("t3_busy", n, 5);
        push(1, 2'b01, 7'h79, 1'b1, "t3_d1");
        push(0, 2'b10, 7'h24, 1'b1, "t3_d0");
        drain("t3");

        // 4: zero with flag set
        apply(4'd0, 1'b1);
        count_busy(12, n);
        check("t4_busy", n, 5);
        push(0, 2'b10, 7'h40, 1'b0, "t4_d0");
        push(1, 2'b11, 7'h7F, 1'b1, "t4_d1");
        drain("t4");

        // 5: 5 then 15 two cycles later -> two conversions, final 15
        apply(4'd5, 1'b0);
        n = 0;
        repeat (2) begin
            @(negedge clk);
            if (busy) n++;
        end
        result = 4'd15;
        count_busy(16, m);
        check("t5_busy_total", n + m, 10);
        check("t5_busy_end", busy, 1'b0);
        push(1, 2'b01, 7'h79, 1'b1, "t5_d1");
        push(0, 2'b10, 7'h12, 1'b1, "t5_d0");
        drain("t5");

        // 6: steady input, scan alternates and no conversion
        push(0, 2'b10, 7'h12, 1'b1, "t6_a");
        push(1, 2'b01, 7'h79, 1'b1, "t6_b");
        push(0, 2'b10, 7'h12, 1'b1, "t6_c");
        push(1, 2'b01, 7'h79, 1'b1, "t6_d");
        count_busy(20, n);
        check("t6_busy", n, 0);
        drain("t6");

        // 7: flag-only change triggers a conversion
        apply(4'd15, 1'b1);
        count_busy(12, n);
        check("t7_busy", n, 5);
        push(0, 2'b10, 7'h12, 1'b0, "t7_d0");
        push(1, 2'b01, 7'h79, 1'b1, "t7_d1");
        drain("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
